// File: rtl/cortocircuito.sv
// Operand forwarding select for the EX stage, plus saturating counters of forwarded operands.
// Selects are zero-cycle combinational; counters update on clk when valid, no backpressure.
module cortocircuito (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs,
    input  logic [4:0]  Rt,
    input  logic [4:0]  RdMem,
    input  logic        EscMem,
    input  logic [4:0]  RdWb,
    input  logic        EscWb,
    input  logic        valid,
    output logic [1:0]  forA,
    output logic [1:0]  forB,
    output logic        fwd_any,
    output logic [15:0] cnt_mem,
    output logic [15:0] cnt_wb
);

    localparam logic [1:0] SelReg = 2'b00;
    localparam logic [1:0] SelMem = 2'b10;
    localparam logic [1:0] SelWb  = 2'b01;

    // MEM is checked first: it carries the younger result for the same register.
    function automatic logic [1:0] pickSource(
        input logic [4:0] src,
        input logic [4:0] rdM,
        input logic       escM,
        input logic [4:0] rdW,
        input logic       escW
    );
        if (escM && (rdM != 5'd0) && (rdM == src)) begin
            return SelMem;
        end
        if (escW && (rdW != 5'd0) && (rdW == src)) begin
            return SelWb;
        end
        return SelReg;
    endfunction

    function automatic logic [15:0] satAdd(input logic [15:0] cur, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cur} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    logic [1:0] memInc;
    logic [1:0] wbInc;

    always_comb begin
        forA    = pickSource(Rs, RdMem, EscMem, RdWb, EscWb);
        forB    = pickSource(Rt, RdMem, EscMem, RdWb, EscWb);
        fwd_any = (forA != SelReg) || (forB != SelReg);
        memInc  = {1'b0, forA == SelMem} + {1'b0, forB == SelMem};
        wbInc   = {1'b0, forA == SelWb} + {1'b0, forB == SelWb};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_mem <= 16'd0;
            cnt_wb  <= 16'd0;
        end else if (valid) begin
            cnt_mem <= satAdd(cnt_mem, memInc);
            cnt_wb  <= satAdd(cnt_wb, wbInc);
        end
    end

endmodule

// File: tb/tb_cortocircuito.sv
// Randomized and directed bench for cortocircuito against a behavioural forwarding/counter model.
module tb_cortocircuito;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Rs, Rt, RdMem, RdWb;
    logic        EscMem, EscWb, valid;
    logic [1:0]  forA, forB;
    logic        fwd_any;
    logic [15:0] cnt_mem, cnt_wb;

    int nChecks = 0;
    int nErrors = 0;
    int modelMem = 0;
    int modelWb = 0;

    cortocircuito dut (
        .clk(clk), .reset(reset), .Rs(Rs), .Rt(Rt), .RdMem(RdMem), .EscMem(EscMem),
        .RdWb(RdWb), .EscWb(EscWb), .valid(valid), .forA(forA), .forB(forB),
        .fwd_any(fwd_any), .cnt_mem(cnt_mem), .cnt_wb(cnt_wb)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input int got, input int exp);
        nChecks++;
        if (got != exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // 2 = take MEM result, 1 = take WB result, 0 = register file.
    function automatic int expSel(input int src);
        if (EscMem && RdMem != 0 && int'(RdMem) == src) return 2;
        if (EscWb && RdWb != 0 && int'(RdWb) == src) return 1;
        return 0;
    endfunction

    task automatic checkComb(input string tag);
        int a, b;
        a = expSel(int'(Rs));
        b = expSel(int'(Rt));
        checkVal({tag, ".forA"}, int'(forA), a);
        checkVal({tag, ".forB"}, int'(forB), b);
        checkVal({tag, ".fwd_any"}, int'(fwd_any), (a != 0 || b != 0) ? 1 : 0);
    endtask

    task automatic clockEdge(input string tag);
        int a, b;
        @(posedge clk);
        a = expSel(int'(Rs));
        b = expSel(int'(Rt));
        if (valid && !reset) begin
            modelMem = modelMem + (a == 2 ? 1 : 0) + (b == 2 ? 1 : 0);
            modelWb  = modelWb + (a == 1 ? 1 : 0) + (b == 1 ? 1 : 0);
            if (modelMem > 65535) modelMem = 65535;
            if (modelWb > 65535) modelWb = 65535;
        end
        #1;
        checkVal({tag, ".cnt_mem"}, int'(cnt_mem), modelMem);
        checkVal({tag, ".cnt_wb"}, int'(cnt_wb), modelWb);
    endtask

    task automatic setIn(input int rs, input int rt, input int rdM, input bit eM,
                         input int rdW, input bit eW);
        Rs = 5'(rs); Rt = 5'(rt); RdMem = 5'(rdM); EscMem = eM; RdWb = 5'(rdW); EscWb = eW;
        #1;
    endtask

    initial begin
        int prevMem, prevWb;
        reset = 1'b1;
        valid = 1'b0;
        setIn(0, 0, 0, 0, 0, 0);
        checkVal("reset.cnt_mem", int'(cnt_mem), 0);
        checkVal("reset.cnt_wb", int'(cnt_wb), 0);
        checkVal("allzero.forA", int'(forA), 0);
        checkVal("allzero.forB", int'(forB), 0);
        checkVal("allzero.fwd_any", int'(fwd_any), 0);

        @(posedge clk);
        #1 reset = 1'b0;

        // Small register range makes matches, register 0 and MEM/WB collisions frequent.
        for (int i = 0; i < 3000; i++) begin
            setIn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom), $urandom_range(0, 3), 1'($urandom));
            valid = 1'($urandom);
            checkComb("rand");
            clockEdge("rand");
        end

        valid = 1'b0;
        setIn(0, 2, 0, 0, 2, 1);
        checkVal("wbB.forB", int'(forB), 1);
        checkVal("wbB.forA", int'(forA), 0);
        checkVal("wbB.fwd_any", int'(fwd_any), 1);

        setIn(5, 2, 5, 1, 0, 0);
        checkVal("memA.forA", int'(forA), 2);
        checkVal("memA.forB", int'(forB), 0);

        setIn(7, 7, 7, 1, 7, 1);
        checkVal("both.forA", int'(forA), 2);
        checkVal("both.forB", int'(forB), 2);
        prevMem = int'(cnt_mem);
        prevWb = int'(cnt_wb);
        valid = 1'b1;
        clockEdge("both");
        checkVal("both.cnt_mem_delta", int'(cnt_mem), (prevMem + 2 > 65535) ? 65535 : prevMem + 2);
        checkVal("both.cnt_wb_same", int'(cnt_wb), prevWb);
        valid = 1'b0;

        setIn(0, 0, 0, 1, 0, 0);
        checkVal("r0.forA", int'(forA), 0);
        setIn(3, 0, 0, 1, 3, 0);
        checkVal("noesc.forA", int'(forA), 0);

        // Asynchronous clear mid-cycle, then hold through an edge while reset is high.
        #2 reset = 1'b1;
        #1;
        modelMem = 0;
        modelWb = 0;
        checkVal("async.cnt_mem", int'(cnt_mem), 0);
        checkVal("async.cnt_wb", int'(cnt_wb), 0);
        setIn(5, 6, 5, 1, 6, 1);
        valid = 1'b1;
        checkComb("inreset");
        clockEdge("inreset");
        reset = 1'b0;

        for (int i = 0; i < 65535; i++) begin
            clockEdge("preload");
        end
        checkVal("full.cnt_mem", int'(cnt_mem), 16'hFFFF);
        checkVal("full.cnt_wb", int'(cnt_wb), 16'hFFFF);
        clockEdge("sat");
        checkVal("sat.cnt_mem", int'(cnt_mem), 16'hFFFF);
        checkVal("sat.cnt_wb", int'(cnt_wb), 16'hFFFF);

        #2 reset = 1'b1;
        #1;
        modelMem = 0;
        modelWb = 0;
        checkVal("clr.cnt_mem", int'(cnt_mem), 0);
        checkVal("clr.cnt_wb", int'(cnt_wb), 0);
        checkComb("clr");
        #1 reset = 1'b0;
        clockEdge("resume");
        checkVal("resume.cnt_mem", int'(cnt_mem), 1);
        checkVal("resume.cnt_wb", int'(cnt_wb), 1);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/cortocircuito.md
CORTOCIRCUITO -- requirements
Module: cortocircuito

Interface
REQ-001 SHALL have port: clk  input  1  single clock; rising edge only; used by the statistics counters.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: Rs  input  5  source register A of the instruction in EX.
REQ-004 SHALL have port: Rt  input  5  source register B of the instruction in EX.
REQ-005 SHALL have port: RdMem  input  5  destination register of the instruction in MEM.
REQ-006 SHALL have port: EscMem  input  1  register-write enable of the instruction in MEM.
REQ-007 SHALL have port: RdWb  input  5  destination register of the instruction in WB.
REQ-008 SHALL have port: EscWb  input  1  register-write enable of the instruction in WB.
REQ-009 SHALL have port: valid  input  1  EX stage holds a real instruction; qualifies counting only.
REQ-010 SHALL have port: forA  output  2  ALU operand A mux select.
REQ-011 SHALL have port: forB  output  2  ALU operand B mux select.
REQ-012 SHALL have port: fwd_any  output  1  high when forA or forB is non-zero.
REQ-013 SHALL have port: cnt_mem  output  16  count of operands forwarded from MEM.
REQ-014 SHALL have port: cnt_wb  output  16  count of operands forwarded from WB.

Function
REQ-015 SHALL use select encoding: 00 = register-file value, 10 = MEM-stage result, 01 = WB-stage result; 11 SHALL never be driven.
REQ-016 forA, forB, fwd_any SHALL be purely combinational from Rs, Rt, RdMem, EscMem, RdWb, EscWb (zero-cycle latency); clk, reset, valid SHALL have no effect on them.
REQ-017 forA SHALL be 10 when EscMem=1, RdMem!=0 and RdMem==Rs.
REQ-018 Otherwise forA SHALL be 01 when EscWb=1, RdWb!=0 and RdWb==Rs; otherwise 00.
REQ-019 forB SHALL follow REQ-017/018 identically with Rt in place of Rs.
REQ-020 When MEM and WB both match the same source, MEM SHALL win (10): it is the younger result.
REQ-021 Register 0 SHALL never be forwarded, regardless of write enables.
REQ-022 A destination match with its write enable low SHALL not forward.
REQ-023 When Rs==Rt, forA and forB SHALL be equal.
REQ-024 fwd_any SHALL equal (forA!=00) OR (forB!=00).
REQ-025 On each rising clk edge with valid=1, cnt_mem SHALL add the number of selects equal to 10 (0, 1 or 2), and cnt_wb SHALL add the number equal to 01.
REQ-026 Counters SHALL saturate at 16'hFFFF: an increment that would exceed it leaves the counter at 16'hFFFF.
REQ-027 With valid=0, counters SHALL hold.

Reset
REQ-028 Asserting reset SHALL immediately, without waiting for clk, clear cnt_mem and cnt_wb to 0, and they SHALL stay 0 while reset is high.
REQ-029 Reset SHALL not affect forA, forB or fwd_any; these SHALL remain valid combinational functions during reset.
REQ-030 Counting SHALL resume on the first rising clk edge after reset deasserts.

Verification
REQ-031 All inputs 0 -> forA=00, forB=00, fwd_any=0.
REQ-032 Rt=2, Rs=0, RdWb=2, EscWb=1, RdMem=0, EscMem=0 -> forB=01, forA=00, fwd_any=1.
REQ-033 Rt=2, Rs=5, RdMem=5, EscMem=1, RdWb=0, EscWb=0 -> forA=10, forB=00.
REQ-034 Rs=Rt=7, RdMem=RdWb=7, EscMem=EscWb=1 -> forA=forB=10; with valid=1 for one edge -> cnt_mem +2, cnt_wb unchanged.
REQ-035 Rs=0, RdMem=0, EscMem=1; then Rs=3, RdWb=3, EscWb=0 -> forA=00 in both cases.
REQ-036 Counters preloaded by 65535 forwarding cycles, then one more counting edge -> cnt_mem stays 16'hFFFF; assert reset between clock edges -> counters read 0 before the next edge.
